// File: rtl/wbx_pkg.sv
// Shared types and constants for the wbx bus master.
package wbx_pkg;

  localparam int WBX_ADR_W       = 17;
  localparam int WBX_DAT_W       = 16;
  localparam int WBX_CNT_W       = 8;
  localparam int WBX_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BSTB = 3'd1,
    ST_BREL = 3'd2,
    ST_ISTB = 3'd3,
    ST_IREL = 3'd4
  } wbx_state_e;

endpackage

// File: rtl/wbx_bus_master_if.sv
// Register bus (wbm) and interrupt-acknowledge bus (wbi) signal bundle.
interface wbx_bus_master_if;
  import wbx_pkg::*;

  logic [WBX_ADR_W-1:0] pin_wbm_adr_o;
  logic [WBX_DAT_W-1:0] pin_wbm_dat_o;
  logic                 pin_wbm_wre_o;
  logic                 pin_wbm_stb_o;
  logic                 pin_wbm_ack_i;
  logic [WBX_DAT_W-1:0] pin_wbm_dat_i;

  logic                 pin_vm_virq_i;
  logic                 pin_wbi_stb_o;
  logic                 pin_wbi_ack_i;
  logic [WBX_DAT_W-1:0] pin_wbi_dat_i;

  modport master (
    output pin_wbm_adr_o, pin_wbm_dat_o, pin_wbm_wre_o, pin_wbm_stb_o, pin_wbi_stb_o,
    input  pin_wbm_ack_i, pin_wbm_dat_i, pin_vm_virq_i, pin_wbi_ack_i, pin_wbi_dat_i
  );

  modport slave (
    input  pin_wbm_adr_o, pin_wbm_dat_o, pin_wbm_wre_o, pin_wbm_stb_o, pin_wbi_stb_o,
    output pin_wbm_ack_i, pin_wbm_dat_i, pin_vm_virq_i, pin_wbi_ack_i, pin_wbi_dat_i
  );

endinterface

// File: rtl/wbx_tmo_counter.sv
// Phase timer shared by the bus and IACK phases: clears on phase entry,
// counts while waiting, flags the last allowed cycle.
module wbx_tmo_counter
  import wbx_pkg::*;
#(
  parameter int TIMEOUT = WBX_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [WBX_CNT_W-1:0] LAST = WBX_CNT_W'(TIMEOUT - 1);

  logic [WBX_CNT_W-1:0] cnt;

  // Count up; the owner clears before LAST is passed, so no wrap occurs.
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (inc)   cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/wbx_bus_master.sv
// Initiator for the VM register bus and the vectored-interrupt acknowledge
// bus. One FSM runs edge-framed strobe/ack cycles on either bus.
module wbx_bus_master
  import wbx_pkg::*;
#(
  parameter int TIMEOUT = WBX_TIMEOUT_DEF
) (
  input  logic                 pin_vm_clk_p,
  input  logic                 pin_vm_init_i,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wre,
  input  logic [WBX_ADR_W-1:0] req_adr,
  input  logic [WBX_DAT_W-1:0] req_dat,
  output logic                 rsp_valid,
  output logic [WBX_DAT_W-1:0] rsp_dat,
  output logic                 rsp_err,
  input  logic                 irq_en,
  output logic                 vec_valid,
  output logic [WBX_DAT_W-1:0] vec_dat,
  output logic                 vec_err,
  wbx_bus_master_if.master     bus
);

  wbx_state_e           state;
  logic                 ready_q;
  logic [WBX_ADR_W-1:0] adr_q;
  logic [WBX_DAT_W-1:0] dat_q;
  logic                 wre_q;
  logic                 wbm_stb_q;
  logic                 wbi_stb_q;

  logic iack_due;
  logic accept;
  logic tmo_clr;
  logic tmo_inc;
  logic tmo_exp;

  assign bus.pin_wbm_adr_o = adr_q;
  assign bus.pin_wbm_dat_o = dat_q;
  assign bus.pin_wbm_wre_o = wre_q;
  assign bus.pin_wbm_stb_o = wbm_stb_q;
  assign bus.pin_wbi_stb_o = wbi_stb_q;

  // Ready is masked combinationally so a pending IACK always wins the IDLE cycle;
  // the timer is cleared in IDLE and on the cycle any phase is left.
  always_comb begin
    iack_due  = bus.pin_vm_virq_i & irq_en;
    req_ready = ready_q & ~iack_due;
    accept    = req_valid & req_ready;
    tmo_clr   = 1'b1;
    case (state)
      ST_BSTB: tmo_clr = bus.pin_wbm_ack_i | tmo_exp;
      ST_BREL: tmo_clr = ~bus.pin_wbm_ack_i | tmo_exp;
      ST_ISTB: tmo_clr = bus.pin_wbi_ack_i | tmo_exp;
      ST_IREL: tmo_clr = ~bus.pin_wbi_ack_i | tmo_exp;
      default: tmo_clr = 1'b1;
    endcase
    tmo_inc = ~tmo_clr;
  end

  wbx_tmo_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (pin_vm_clk_p),
    .rst     (pin_vm_init_i),
    .clr     (tmo_clr),
    .inc     (tmo_inc),
    .expired (tmo_exp)
  );

  // Main sequencer: strobe phase, then release phase until ack drops.
  always_ff @(posedge pin_vm_clk_p) begin
    if (pin_vm_init_i) begin
      state     <= ST_IDLE;
      ready_q   <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      wre_q     <= 1'b0;
      wbm_stb_q <= 1'b0;
      wbi_stb_q <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      vec_valid <= 1'b0;
      vec_dat   <= '0;
      vec_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      vec_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iack_due) begin
            state     <= ST_ISTB;
            wbi_stb_q <= 1'b1;
            ready_q   <= 1'b0;
          end else if (accept) begin
            state     <= ST_BSTB;
            adr_q     <= req_adr;
            dat_q     <= req_dat;
            wre_q     <= req_wre;
            wbm_stb_q <= 1'b1;
            ready_q   <= 1'b0;
          end else begin
            ready_q   <= 1'b1;
          end
        end
        ST_BSTB: begin
          if (bus.pin_wbm_ack_i) begin
            state     <= ST_BREL;
            wbm_stb_q <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_dat   <= wre_q ? '0 : bus.pin_wbm_dat_i;
            rsp_err   <= 1'b0;
          end else if (tmo_exp) begin
            state     <= ST_BREL;
            wbm_stb_q <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_dat   <= '0;
            rsp_err   <= 1'b1;
          end
        end
        ST_BREL: begin
          if (!bus.pin_wbm_ack_i || tmo_exp) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        ST_ISTB: begin
          if (bus.pin_wbi_ack_i) begin
            state     <= ST_IREL;
            wbi_stb_q <= 1'b0;
            vec_valid <= 1'b1;
            vec_dat   <= bus.pin_wbi_dat_i;
            vec_err   <= 1'b0;
          end else if (tmo_exp) begin
            state     <= ST_IREL;
            wbi_stb_q <= 1'b0;
            vec_valid <= 1'b1;
            vec_dat   <= '0;
            vec_err   <= 1'b1;
          end
        end
        ST_IREL: begin
          if (!bus.pin_wbi_ack_i || tmo_exp) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          ready_q   <= 1'b0;
          wbm_stb_q <= 1'b0;
          wbi_stb_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
